ddr_axi_arbiter: RTL
====================

# ddr_axi_arbiter

Two-master AXI4 arbiter that shares the single DDR-C channel between the FireSim host-memory master (port s0) and the host DMA loader (port s1). It sits between those masters and the shell DDR interface (`cl_sh_ddr_*` / `sh_cl_ddr_*`), inside the 64-bit data domain ahead of the 512-bit padding. It grants AW and AR independently with round-robin fairness and tags each transaction ID with its source. It returns B and R responses to the issuing master using that tag.

## Interface
Parameters:
- ADDR_W, 64, address width on all ports
- DATA_W, 64, data width on all ports; STRB_W = DATA_W/8
- ID_W, 16, master-side ID width; slave-side IDs are ID_W-1 bits
- MAX_OUT, 8, depth of the write-order FIFO (power of 2, ≥2)

Ports (x = 0,1):
- clock  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- sx_aw{valid,addr,len,size,id}  in  1/ADDR_W/8/3/ID_W-1  write-address request from master x
- sx_awready  out  1  write-address accept to master x
- sx_w{valid,data,strb,last}  in  1/DATA_W/STRB_W/1  write data from master x
- sx_wready  out  1  write-data accept to master x
- sx_b{valid,resp,id}  out  1/2/ID_W-1  write response to master x
- sx_bready  in  1  write-response accept from master x
- sx_ar{valid,addr,len,size,id}  in  1/ADDR_W/8/3/ID_W-1  read-address request from master x
- sx_arready  out  1  read-address accept to master x
- sx_r{valid,data,resp,last,id}  out  1/DATA_W/2/1/ID_W-1  read data to master x
- sx_rready  in  1  read-data accept from master x
- m_aw{valid,addr,len,size,id}, m_w{valid,data,strb,last}, m_bready, m_ar{valid,addr,len,size,id}, m_rready  out  widths as above, ID ports ID_W  requests to DDR
- m_awready, m_wready, m_b{valid,resp,id}, m_arready, m_r{valid,data,resp,last,id}  in  widths as above  responses from DDR

## Operation
- AW and AR each have one arbiter with states IDLE and LOCKED, plus a 1-bit last-grant pointer.
- In IDLE, a single valid request wins. If both requests are valid, the source not named by the pointer wins.
- The request is driven to m_* in the same cycle. If it is not accepted, the arbiter enters LOCKED and holds that grant until the handshake completes.
- The arbiter never switches source while m_*valid is high without ready.
- On handshake: pointer ← winner, state → IDLE.
- Outgoing ID is {src, sx_id}, with the source bit in the MSB.
- The AW arbiter does not assert m_awvalid while the write-order FIFO is full.
- On each AW handshake, src is pushed into the write-order FIFO.
- W channel routing:
  - m_w* is taken from the source at the FIFO head; m_wvalid = !empty & s[head]_wvalid.
  - s[head]_wready = !empty & m_wready; the other source's wready = 0.
  - The FIFO is popped on a W handshake with wlast = 1.
- B and R responses are routed by m_bid / m_rid MSB to sx_b* / sx_r*, with the MSB stripped.
- m_bready = s[bid MSB]_bready and m_rready = s[rid MSB]_rready. Responses are never dropped or reordered.
- W beats for a burst are accepted no earlier than the cycle after that burst's AW handshake.
- Simultaneous FIFO push and pop in one cycle are both honoured; the count is unchanged. Push while full cannot occur.
- Reset values:
  - All valid outputs are 0 and all ready outputs are 0.
  - Arbiters are IDLE with pointer = 1, so s0 wins the first contest.
  - The FIFO is empty.
- Reset mid-burst abandons all in-flight state. The DDR side must be reset together with this block.

## Timing
- AW and AR paths have zero cycles of added latency; all request and response paths are combinational muxes.
- Registered state is limited to: arbiter state, pointers, and FIFO pointers and count.
- The write-order FIFO has one cycle from push to visibility at the head.
- sx_awready = (grant == x) & m_awready & !fifo_full. sx_arready = (grant == x) & m_arready.
- With both masters continuously requesting, grants alternate 0,1,0,1 on consecutive handshakes.

## Test plan
- Reset, then s0 and s1 both assert AR on the same cycle with m_arready = 1 → s0 granted in cycle 0 and s1 in cycle 1; m_arid MSBs are 0 then 1.
- s1 issues AW id = 0x05, len = 3, then 4 W beats; m_awready is held low for 5 cycles → m_aw* stays stable and m_awid = 0x8005. Exactly 4 W beats pass with wlast on the 4th, and s1_bid = 0x05.
- s0 and s1 each issue AW len = 1 back-to-back, and s1 presents W first → s1's W is stalled until s0's 2 beats complete, so W order matches AW order.
- 8 AWs are issued with W withheld (MAX_OUT = 8) → the 9th AW is not accepted (awready = 0). After one burst's wlast it is accepted the following cycle.
- R data interleaved with m_rid 0x0003 then 0x8003, with s1_rready = 0 → s0 receives its beat. The s1 beat stalls m_rready until s1_rready rises; no data is lost.
- Assert reset mid-read-burst → all outputs go to 0 asynchronously. After deassertion, the first contest grants s0.

Source files
------------

// File: rtl/ddr_axi_arbiter.sv
// Two-master AXI4 arbiter for the shared DDR-C channel: round-robin AW/AR grants,
// source-tagged IDs, a write-order FIFO for W routing and ID-based B/R return.
module ddr_axi_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 16,
    parameter int MAX_OUT = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    // master 0
    input  logic                  s0_awvalid,
    input  logic [ADDR_W-1:0]     s0_awaddr,
    input  logic [7:0]            s0_awlen,
    input  logic [2:0]            s0_awsize,
    input  logic [ID_W-2:0]       s0_awid,
    output logic                  s0_awready,
    input  logic                  s0_wvalid,
    input  logic [DATA_W-1:0]     s0_wdata,
    input  logic [DATA_W/8-1:0]   s0_wstrb,
    input  logic                  s0_wlast,
    output logic                  s0_wready,
    output logic                  s0_bvalid,
    output logic [1:0]            s0_bresp,
    output logic [ID_W-2:0]       s0_bid,
    input  logic                  s0_bready,
    input  logic                  s0_arvalid,
    input  logic [ADDR_W-1:0]     s0_araddr,
    input  logic [7:0]            s0_arlen,
    input  logic [2:0]            s0_arsize,
    input  logic [ID_W-2:0]       s0_arid,
    output logic                  s0_arready,
    output logic                  s0_rvalid,
    output logic [DATA_W-1:0]     s0_rdata,
    output logic [1:0]            s0_rresp,
    output logic                  s0_rlast,
    output logic [ID_W-2:0]       s0_rid,
    input  logic                  s0_rready,
    // master 1
    input  logic                  s1_awvalid,
    input  logic [ADDR_W-1:0]     s1_awaddr,
    input  logic [7:0]            s1_awlen,
    input  logic [2:0]            s1_awsize,
    input  logic [ID_W-2:0]       s1_awid,
    output logic                  s1_awready,
    input  logic                  s1_wvalid,
    input  logic [DATA_W-1:0]     s1_wdata,
    input  logic [DATA_W/8-1:0]   s1_wstrb,
    input  logic                  s1_wlast,
    output logic                  s1_wready,
    output logic                  s1_bvalid,
    output logic [1:0]            s1_bresp,
    output logic [ID_W-2:0]       s1_bid,
    input  logic                  s1_bready,
    input  logic                  s1_arvalid,
    input  logic [ADDR_W-1:0]     s1_araddr,
    input  logic [7:0]            s1_arlen,
    input  logic [2:0]            s1_arsize,
    input  logic [ID_W-2:0]       s1_arid,
    output logic                  s1_arready,
    output logic                  s1_rvalid,
    output logic [DATA_W-1:0]     s1_rdata,
    output logic [1:0]            s1_rresp,
    output logic                  s1_rlast,
    output logic [ID_W-2:0]       s1_rid,
    input  logic                  s1_rready,
    // DDR side
    output logic                  m_awvalid,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic [7:0]            m_awlen,
    output logic [2:0]            m_awsize,
    output logic [ID_W-1:0]       m_awid,
    input  logic                  m_awready,
    output logic                  m_wvalid,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wlast,
    input  logic                  m_wready,
    input  logic                  m_bvalid,
    input  logic [1:0]            m_bresp,
    input  logic [ID_W-1:0]       m_bid,
    output logic                  m_bready,
    output logic                  m_arvalid,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [ID_W-1:0]       m_arid,
    input  logic                  m_arready,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic [ID_W-1:0]       m_rid,
    output logic                  m_rready
);

    localparam int PTR_W = $clog2(MAX_OUT);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(MAX_OUT);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    arb_state_e aw_state_q, aw_state_d, ar_state_q, ar_state_d;
    logic aw_ptr_q, aw_ptr_d, aw_grant_q, aw_grant_d, aw_grant, aw_hs;
    logic ar_ptr_q, ar_ptr_d, ar_grant_q, ar_grant_d, ar_grant, ar_hs;

    logic             fifo_mem [MAX_OUT];
    logic [PTR_W-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [PTR_W:0]   fifo_cnt_q, fifo_cnt_d;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop, w_src;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aw_state_q <= ARB_IDLE;
            aw_ptr_q   <= 1'b1;
            aw_grant_q <= 1'b0;
            ar_state_q <= ARB_IDLE;
            ar_ptr_q   <= 1'b1;
            ar_grant_q <= 1'b0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            aw_state_q <= aw_state_d;
            aw_ptr_q   <= aw_ptr_d;
            aw_grant_q <= aw_grant_d;
            ar_state_q <= ar_state_d;
            ar_ptr_q   <= ar_ptr_d;
            ar_grant_q <= ar_grant_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // NOTE: the order storage needs no reset; the count alone defines which entries are live.
    always_ff @(posedge clock) begin
        if (fifo_push) fifo_mem[fifo_wr_q] <= aw_grant;
    end

    // Grant decode and next state; a lock holds the previous grant until handshake.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        aw_grant   = aw_grant_q;
        ar_grant   = ar_grant_q;
        if (aw_state_q == ARB_IDLE)
            aw_grant = (s0_awvalid && s1_awvalid) ? ~aw_ptr_q : s1_awvalid;
        if (ar_state_q == ARB_IDLE)
            ar_grant = (s0_arvalid && s1_arvalid) ? ~ar_ptr_q : s1_arvalid;

        aw_state_d = aw_state_q;
        aw_ptr_d   = aw_ptr_q;
        aw_grant_d = aw_grant_q;
        if (aw_hs) begin
            aw_state_d = ARB_IDLE;
            aw_ptr_d   = aw_grant;
        end else if (m_awvalid) begin
            aw_state_d = ARB_LOCKED;
            aw_grant_d = aw_grant;
        end

        ar_state_d = ar_state_q;
        ar_ptr_d   = ar_ptr_q;
        ar_grant_d = ar_grant_q;
        if (ar_hs) begin
            ar_state_d = ARB_IDLE;
            ar_ptr_d   = ar_grant;
        end else if (m_arvalid) begin
            ar_state_d = ARB_LOCKED;
            ar_grant_d = ar_grant;
        end

        fifo_wr_d  = fifo_push ? fifo_wr_q + PTR_ONE : fifo_wr_q;
        fifo_rd_d  = fifo_pop  ? fifo_rd_q + PTR_ONE : fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q;
        if (fifo_push && !fifo_pop) fifo_cnt_d = fifo_cnt_q + CNT_ONE;
        if (!fifo_push && fifo_pop) fifo_cnt_d = fifo_cnt_q - CNT_ONE;
    end

    // Request-side outputs; valids and readies are forced low while reset is held.
    always_comb begin
        m_awvalid  = !reset && !fifo_full && (aw_grant ? s1_awvalid : s0_awvalid);
        m_awaddr   = aw_grant ? s1_awaddr : s0_awaddr;
        m_awlen    = aw_grant ? s1_awlen  : s0_awlen;
        m_awsize   = aw_grant ? s1_awsize : s0_awsize;
        m_awid     = {aw_grant, aw_grant ? s1_awid : s0_awid};
        s0_awready = !reset && !aw_grant && m_awready && !fifo_full;
        s1_awready = !reset &&  aw_grant && m_awready && !fifo_full;

        m_arvalid  = !reset && (ar_grant ? s1_arvalid : s0_arvalid);
        m_araddr   = ar_grant ? s1_araddr : s0_araddr;
        m_arlen    = ar_grant ? s1_arlen  : s0_arlen;
        m_arsize   = ar_grant ? s1_arsize : s0_arsize;
        m_arid     = {ar_grant, ar_grant ? s1_arid : s0_arid};
        s0_arready = !reset && !ar_grant && m_arready;
        s1_arready = !reset &&  ar_grant && m_arready;
    end

    assign aw_hs      = m_awvalid && m_awready;
    assign ar_hs      = m_arvalid && m_arready;
    assign fifo_full  = (fifo_cnt_q == CNT_FULL);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_push  = aw_hs;
    assign fifo_pop   = m_wvalid && m_wready && m_wlast;
    assign w_src      = fifo_mem[fifo_rd_q];

    // W follows AW order: only the source at the FIFO head may drive data.
    assign m_wvalid  = !reset && !fifo_empty && (w_src ? s1_wvalid : s0_wvalid);
    assign m_wdata   = w_src ? s1_wdata : s0_wdata;
    assign m_wstrb   = w_src ? s1_wstrb : s0_wstrb;
    assign m_wlast   = w_src ? s1_wlast : s0_wlast;
    assign s0_wready = !reset && !fifo_empty && !w_src && m_wready;
    assign s1_wready = !reset && !fifo_empty &&  w_src && m_wready;

    assign s0_bvalid = !reset && m_bvalid && !m_bid[ID_W-1];
    assign s1_bvalid = !reset && m_bvalid &&  m_bid[ID_W-1];
    assign s0_bresp  = m_bresp;
    assign s1_bresp  = m_bresp;
    assign s0_bid    = m_bid[ID_W-2:0];
    assign s1_bid    = m_bid[ID_W-2:0];
    assign m_bready  = !reset && (m_bid[ID_W-1] ? s1_bready : s0_bready);

    assign s0_rvalid = !reset && m_rvalid && !m_rid[ID_W-1];
    assign s1_rvalid = !reset && m_rvalid &&  m_rid[ID_W-1];
    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s1_rresp  = m_rresp;
    assign s0_rlast  = m_rlast;
    assign s1_rlast  = m_rlast;
    assign s0_rid    = m_rid[ID_W-2:0];
    assign s1_rid    = m_rid[ID_W-2:0];
    assign m_rready  = !reset && (m_rid[ID_W-1] ? s1_rready : s0_rready);

endmodule
